// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port between two writeback requesters.
// Define REG_WR_ARB_CLEAR_EN to zero registers 0..NREG-1 after reset before accepting traffic.
module reg_wr_arbiter #(
   parameter int n    = 32,
   parameter int NREG = 32
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         req0_valid,
   input  logic [4:0]   req0_addr,
   input  logic [n-1:0] req0_data,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [4:0]   req1_addr,
   input  logic [n-1:0] req1_data,
   output logic         req1_ready,
   output logic [4:0]   Rw,
   output logic [n-1:0] busW,
   output logic         RegWr,
   output logic         grant_id,
   output logic         busy
);

   if (NREG < 1 || NREG > 32) begin : g_nreg_chk
      $error("reg_wr_arbiter: NREG must be in 1..32");
   end

   logic last;
   logic run;
   logic accept;
   logic winner;

`ifdef REG_WR_ARB_CLEAR_EN
   typedef enum logic {CLR, RUN} state_t;
   localparam logic [4:0] LASTREG = 5'(NREG - 1);

   state_t     state, state_nxt;
   logic [4:0] cnt, cnt_nxt;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= CLR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == CLR) begin
         cnt_nxt = cnt + 5'd1;
         if (cnt == LASTREG) state_nxt = RUN;
      end
   end

   assign busy = (state == CLR);
   assign run  = Resetn & (state == RUN);
`else
   assign busy = 1'b0;
   assign run  = Resetn;
`endif

   // last==1 means req1 won most recently, so req0 takes the next contention
   assign req0_ready = run & req0_valid & (~req1_valid | last);
   assign req1_ready = run & req1_valid & (~req0_valid | ~last);
   assign accept     = req0_ready | req1_ready;
   assign winner     = req1_ready;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         RegWr    <= 1'b0;
         Rw       <= '0;
         busW     <= '0;
         grant_id <= 1'b0;
         last     <= 1'b1;
      end else begin
         RegWr <= 1'b0;
`ifdef REG_WR_ARB_CLEAR_EN
         if (busy) begin
            RegWr <= 1'b1;
            Rw    <= cnt;
            busW  <= '0;
         end else
`endif
         if (accept) begin
            RegWr    <= 1'b1;
            Rw       <= winner ? req1_addr : req0_addr;
            busW     <= winner ? req1_data : req0_data;
            grant_id <= winner;
            last     <= winner;
         end
      end
   end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: scoreboard of accepted writes plus a negedge-write register file model.
module tb_reg_wr_arbiter;
   localparam int N    = 32;
   localparam int NREG = 32;

   logic         Clock = 1'b0;
   logic         Resetn = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic [4:0]   req0_addr = '0, req1_addr = '0;
   logic [N-1:0] req0_data = '0, req1_data = '0;
   logic         req0_ready, req1_ready, RegWr, grant_id, busy;
   logic [4:0]   Rw;
   logic [N-1:0] busW;

   reg_wr_arbiter #(.n(N), .NREG(NREG)) dut (
      .Clock(Clock), .Resetn(Resetn),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .Rw(Rw), .busW(busW), .RegWr(RegWr), .grant_id(grant_id), .busy(busy)
   );

   always #5 Clock = ~Clock;

   // register file captures on the negedge following the registered write
   logic [N-1:0] mem [32];
   always @(negedge Clock) if (RegWr) mem[Rw] <= busW;

   typedef struct packed {
      logic [4:0]   a;
      logic [N-1:0] d;
      logic         g;
   } wr_t;

   wr_t          q[$];
   int           ncmp = 0, nerr = 0;
   logic [4:0]   h_rw;
   logic [N-1:0] h_bw;
   logic         h_g;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive one cycle; e0/e1 are the expected readys for this input pattern
   task automatic step(input logic v0, input logic [4:0] a0, input logic [N-1:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [N-1:0] d1,
                       input logic e0, input logic e1);
      wr_t w;
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      #1;
      chk("req0_ready", 64'(req0_ready), 64'(e0));
      chk("req1_ready", 64'(req1_ready), 64'(e1));
      chk("busy_run", 64'(busy), 64'(0));
      if (e0) q.push_back(wr_t'{a: a0, d: d0, g: 1'b0});
      if (e1) q.push_back(wr_t'{a: a1, d: d1, g: 1'b1});
      @(posedge Clock); #1;
      chk("RegWr", 64'(RegWr), 64'(e0 | e1));
      if (q.size() != 0) begin
         w = q.pop_front();
         h_rw = w.a; h_bw = w.d; h_g = w.g;
      end
      chk("Rw", 64'(Rw), 64'(h_rw));
      chk("busW", 64'(busW), 64'(h_bw));
      chk("grant_id", 64'(grant_id), 64'(h_g));
   endtask

   task automatic idle();
      step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input logic keep_valid);
      Resetn = 1'b0;
      #1;
      chk("rst_RegWr", 64'(RegWr), 64'(0));
      chk("rst_Rw", 64'(Rw), 64'(0));
      chk("rst_busW", 64'(busW), 64'(0));
      chk("rst_grant", 64'(grant_id), 64'(0));
      chk("rst_req0_ready", 64'(req0_ready), 64'(0));
      chk("rst_req1_ready", 64'(req1_ready), 64'(0));
      h_rw = '0; h_bw = '0; h_g = 1'b0;
      q.delete();
      @(posedge Clock); #1;
      if (!keep_valid) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      Resetn = 1'b1;
      #1;
`ifdef REG_WR_ARB_CLEAR_EN
      for (int i = 0; i < NREG; i++) begin
         chk("clr_busy", 64'(busy), 64'(1));
         chk("clr_req0_ready", 64'(req0_ready), 64'(0));
         chk("clr_req1_ready", 64'(req1_ready), 64'(0));
         @(posedge Clock); #1;
         chk("clr_RegWr", 64'(RegWr), 64'(1));
         chk("clr_Rw", 64'(Rw), 64'(i));
         chk("clr_busW", 64'(busW), 64'(0));
      end
      h_rw = 5'(NREG - 1);
`else
      chk("busy_off", 64'(busy), 64'(0));
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | N'(i);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #2;
      do_reset(1'b0);

      // fairness under continuous contention
      step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b1, 1'b0);
      step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0, 1'b1);
      step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b1, 1'b0);
      step(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 1'b0, 1'b1);

      step(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, '0, 1'b1, 1'b0);
      idle();
      chk("mem1", 64'(mem[1]), 64'(32'hA));
      chk("mem2", 64'(mem[2]), 64'(32'hB));
      chk("mem3", 64'(mem[3]), 64'(32'h1234));

      // gapped pulses on req1; outputs hold while idle
      step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
      idle();
      idle();
      step(1'b0, 5'd0, '0, 1'b1, 5'd8, 32'h88, 1'b0, 1'b1);
      idle();

      // same-address contention: req0 first, req1 overwrites
      step(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b1, 1'b0);
      step(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'h22, 1'b0, 1'b1);
      idle();
      chk("mem5", 64'(mem[5]), 64'(32'h22));
      chk("mem7", 64'(mem[7]), 64'(32'h77));
      chk("mem8", 64'(mem[8]), 64'(32'h88));

      // address 0 and back-to-back to the same register
      step(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b1);
      step(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, '0, 1'b1, 1'b0);
      idle();
      chk("mem0", 64'(mem[0]), 64'(32'hBEEF));

      // reset while RegWr is high; req0 won last, reset must restore req0 priority
      step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, '0, 1'b1, 1'b0);
      #1;
      do_reset(1'b0);
`ifndef REG_WR_ARB_CLEAR_EN
      chk("mem9_dropped", 64'(mem[9]), 64'(32'hC0DE_0009));
`endif
      step(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b1, 1'b0);
      step(1'b0, 5'd0, '0, 1'b1, 5'd11, 32'hBB, 1'b0, 1'b1);
      idle();
      chk("mem10", 64'(mem[10]), 64'(32'hAA));
      chk("mem11", 64'(mem[11]), 64'(32'hBB));

`ifdef REG_WR_ARB_CLEAR_EN
      // sweep with a pending request held off until RUN
      for (int i = 0; i < 32; i++) mem[i] = 32'h5A00_0000 | N'(i + 1);
      req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h55;
      do_reset(1'b1);
      step(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, '0, 1'b1, 1'b0);
      idle();
      for (int i = 0; i < NREG; i++)
         chk($sformatf("clr_mem%0d", i), 64'(mem[i]), (i == 4) ? 64'(32'h55) : 64'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Sequences the single write port (Rw/busW/RegWr) of the 32-entry register file and shares it between two writeback requesters, e.g. ALU result and load result.
- Fair round-robin arbitration over valid/ready handshakes; one write granted per cycle.
- Outputs are registered on the posedge so the register file captures them on the following negedge.
- Optional post-reset clear sweep zeroes every register before normal traffic is accepted.

Parameters:
- n, 32, data bus width; matches register file busW.
- NREG, 32, number of register file entries swept by the clear sequence; must be ≤ 32.

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Resetn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  5  requester 0 destination register.
- req0_data  in  n  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  5  requester 1 destination register.
- req1_data  in  n  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle (combinational).
- Rw  out  5  register file write address (registered).
- busW  out  n  register file write data (registered).
- RegWr  out  1  register file write enable (registered).
- grant_id  out  1  source of the current RegWr pulse: 0 = req0, 1 = req1 (registered).
- busy  out  1  clear sweep in progress; no requests accepted.

Behaviour:
- Reset (asynchronous, Resetn=0):
  - RegWr=0, Rw=0, busW=0, grant_id=0.
  - req0_ready=req1_ready=0.
  - Priority pointer last=1, so req0 wins the first contention.
  - Sweep counter=0.
  - State = CLR if the macro is defined, else RUN.
  - Reset asserted mid-sweep or mid-write drops RegWr immediately; the sweep restarts from 0.
- States:
  - CLR: busy=1, both readys 0. Each cycle registers RegWr=1, Rw=cnt, busW=0, then increments cnt. When cnt==NREG-1 is issued, go to RUN.
  - RUN: busy=0. RUN holds until reset.
- Arbitration in RUN (combinational):
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: the requester other than last gets ready.
  - Neither valid: both readys 0.
  - ready is never asserted without the matching valid.
  - At most one ready is high per cycle.
- Handshake: valid & ready at a posedge means the write is accepted.
  - On that edge: Rw<=addr, busW<=data, RegWr<=1, grant_id<=winner, last<=winner.
  - With no handshake: RegWr<=0; Rw, busW and grant_id hold.
- Latency: request accepted at posedge k. RegWr is high from posedge k to posedge k+1, and the register file writes at the negedge inside that cycle. Peak throughput is one write per cycle.
- Requester rules: a requester keeps valid, addr and data stable until ready. The arbiter does not check this.
- Fairness: with both valid continuously, grants alternate 0,1,0,1. Worst-case wait is 1 cycle.
- Same-address contention: both requesters targeting the same register are serialized in grant order. The later grant overwrites the earlier.
- Address 0 is an ordinary register; writes to it are forwarded unchanged.
- Back-to-back writes to the same address are allowed.

Optional Feature:
- REG_WR_ARB_CLEAR_EN defined: after reset release the block runs CLR for NREG cycles, writing 0 to registers 0..NREG-1. RUN is entered on the cycle after the last clear write.
- REG_WR_ARB_CLEAR_EN undefined: the CLR state and counter are absent, the block enters RUN directly, and busy is tied to 0.

Test Plan:
- Reset, then only req0_valid=1, addr=3, data=0x1234 → req0_ready=1 in the same cycle. Next cycle RegWr=1, Rw=3, busW=0x1234, grant_id=0. The register file reads back 0x1234 at Ra=3.
- Both valid continuously (req0 addr 1 data 0xA, req1 addr 2 data 0xB) for 4 cycles → grants 0,1,0,1. RegWr stays high on every cycle.
- Both valid targeting addr 5, req0 data 0x11, req1 data 0x22 → req0 granted first, then req1. Final mem[5]=0x22.
- Valid pulses with gaps (req1 only, then idle, then req1) → RegWr=1 only in cycles after handshakes. Rw and busW hold during idle.
- Resetn dropped while RegWr=1 → RegWr=0 immediately, with no clock edge. After release, the first contention is granted to req0.
- With REG_WR_ARB_CLEAR_EN: preload registers with nonzero values, then release reset with req0_valid=1 → busy=1 and readys 0 for 32 cycles. Rw steps 0..31 with busW=0. req0 is accepted in the first RUN cycle, and all registers read 0 except the one just written.
